// File: rtl/clock_works.sv
// -----------------------------------------------------------------------------
// clock_works : board-level clock/reset conditioner.
//
// Divides the board clock CLK by 2^SLOW to produce the core clock clk, and
// produces a stretched active-low core reset resetn. resetn is asserted
// asynchronously and released synchronously, on a clk falling edge.
//
// Parameters
//   SLOW       divide exponent (0..30); 0 means clk = CLK
//   RST_CYCLES clk falling edges resetn stays low after release (1..255)
//
// Ports
//   CLK     in   board clock, the only clock
//   RESET   in   board reset, asynchronous, active-low
//   clk     out  divided core clock
//   resetn  out  core reset, active-low
//
// Build option
//   CLOCK_WORKS_SIM_FAST_EN : when defined, the divide exponent becomes
//   max(SLOW-4, 0) so that simulations run faster. RST_CYCLES is unaffected.
// -----------------------------------------------------------------------------
module clock_works #(
    parameter int SLOW       = 0,
    parameter int RST_CYCLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    output logic clk,
    output logic resetn
);

`ifdef CLOCK_WORKS_SIM_FAST_EN
    localparam int EXP = (SLOW > 4) ? SLOW - 4 : 0;
`else
    localparam int EXP = SLOW;
`endif

    localparam logic [7:0] RST_MAX = 8'(RST_CYCLES);

    logic [1:0] sync_q;
    logic       rst_sync;
    logic       wrap;
    logic [7:0] stretch_cnt;
    logic       resetn_q;

    // Release of RESET is re-timed through two flops; assertion is immediate.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_sync = sync_q[1];

    generate
        if (EXP == 0) begin : g_nodiv
            assign clk  = CLK;
            assign wrap = 1'b1;
        end else begin : g_div
            localparam logic [EXP-1:0] DIV_ONE = EXP'(1);
            logic [EXP-1:0] div_cnt;

            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    div_cnt <= '0;
                end else if (rst_sync) begin
                    div_cnt <= div_cnt + DIV_ONE;
                end else begin
                    div_cnt <= '0;
                end
            end

            // The counter MSB is a flop output, so clk is glitch-free.
            assign clk = div_cnt[EXP-1];
            // All-ones means the next CLK posedge is a clk falling edge.
            assign wrap = &div_cnt;
        end
    endgenerate

    // Stretch counter advances once per clk falling edge and saturates.
    // resetn is set on the same edge the count reaches RST_MAX, so it
    // changes half a clk period ahead of the next clk rising edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stretch_cnt <= 8'd0;
            resetn_q    <= 1'b0;
        end else if (rst_sync && wrap && (stretch_cnt < RST_MAX)) begin
            stretch_cnt <= stretch_cnt + 8'd1;
            if ((stretch_cnt + 8'd1) == RST_MAX) begin
                resetn_q <= 1'b1;
            end
        end
    end

    assign resetn = resetn_q;

endmodule

// File: tb/tb_clock_works.sv
// -----------------------------------------------------------------------------
// tb_clock_works : self-checking bench for clock_works.
//
// Three instances share CLK and RESET:
//   a : SLOW=2, RST_CYCLES=4
//   b : SLOW=0, RST_CYCLES=1
//   c : SLOW=3, RST_CYCLES=4
// Expected outputs come from closed-form expressions of the post-release CLK
// posedge index k (k=1 is the first posedge after RESET rises).
// -----------------------------------------------------------------------------
module tb_clock_works;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    logic clk_a, resetn_a, clk_b, resetn_b, clk_c, resetn_c;

    always #5 CLK = ~CLK;

    clock_works #(.SLOW(2), .RST_CYCLES(4)) u_a (
        .CLK(CLK), .RESET(RESET), .clk(clk_a), .resetn(resetn_a));
    clock_works #(.SLOW(0), .RST_CYCLES(1)) u_b (
        .CLK(CLK), .RESET(RESET), .clk(clk_b), .resetn(resetn_b));
    clock_works #(.SLOW(3), .RST_CYCLES(4)) u_c (
        .CLK(CLK), .RESET(RESET), .clk(clk_c), .resetn(resetn_c));

    function automatic int eff(input int s);
`ifdef CLOCK_WORKS_SIM_FAST_EN
        return (s > 4) ? s - 4 : 0;
`else
        return s;
`endif
    endfunction

    localparam int EA = eff(2);
    localparam int EB = eff(0);
    localparam int EC = eff(3);

    // k=0 stands for "held in reset / rst_sync not yet high".
    // rst_sync rises on posedge 2; div_cnt after posedge k is (k-2) mod 2^e.
    function automatic logic exp_clk(input int e, input int k, input logic lvl);
        int p;
        if (e == 0) return lvl;
        if (k < 2) return 1'b0;
        p = 1 << e;
        return (((k - 2) % p) >= (p / 2)) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic exp_rstn(input int e, input int r, input int k);
        if (k < 1) return 1'b0;
        return (k >= 2 + r * (1 << e)) ? 1'b1 : 1'b0;
    endfunction

    typedef struct {
        int   k;
        logic ca, ra, cb, rb, cc, rc;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int k, input logic act, input logic expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s k=%0d t=%0t actual=%b required=%b", name, k, $time, act, expv);
        end
    endtask

    task automatic push_exp(input int k, input logic lvl);
        exp_t e;
        e.k  = k;
        e.ca = exp_clk(EA, k, lvl);  e.ra = exp_rstn(EA, 4, k);
        e.cb = exp_clk(EB, k, lvl);  e.rb = exp_rstn(EB, 1, k);
        e.cc = exp_clk(EC, k, lvl);  e.rc = exp_rstn(EC, 4, k);
        sbq.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, -1, 1'b1, 1'b0);
            return;
        end
        e = sbq.pop_front();
        check({tag, "_clk_a"},    e.k, clk_a,    e.ca);
        check({tag, "_resetn_a"}, e.k, resetn_a, e.ra);
        check({tag, "_clk_b"},    e.k, clk_b,    e.cb);
        check({tag, "_resetn_b"}, e.k, resetn_b, e.rb);
        check({tag, "_clk_c"},    e.k, clk_c,    e.cc);
        check({tag, "_resetn_c"}, e.k, resetn_c, e.rc);
    endtask

    // Walk n CLK cycles, checking both phases. hold=1 keeps k at 0.
    task automatic run_seq(input string tag, input int n, input bit hold);
        for (int i = 1; i <= n; i++) begin
            @(posedge CLK);
            push_exp(hold ? 0 : i, 1'b1);
            #1 pop_cmp(tag);
            @(negedge CLK);
            push_exp(hold ? 0 : i, 1'b0);
            #1 pop_cmp(tag);
        end
    endtask

    task automatic release_reset();
        @(negedge CLK);
        #2 RESET = 1'b1;
    endtask

    // Drop RESET 3 ns after a posedge and check before any further edge.
    task automatic async_assert(input string tag, input int width_ns);
        @(posedge CLK);
        #3 RESET = 1'b0;
        if (width_ns > 0) #(width_ns) RESET = 1'b1;
        #1;
        check({tag, "_async_resetn_a"}, 0, resetn_a, 1'b0);
        check({tag, "_async_clk_a"},    0, clk_a,    exp_clk(EA, 0, CLK));
        check({tag, "_async_resetn_b"}, 0, resetn_b, 1'b0);
        check({tag, "_async_resetn_c"}, 0, resetn_c, 1'b0);
        check({tag, "_async_clk_c"},    0, clk_c,    exp_clk(EC, 0, CLK));
    endtask

    typedef struct {
        string name;
        int    hold_cycles;
        int    run_cycles;
        int    glitch_ns;   // 0: steady assertion afterwards, >0: short pulse
        logic  final_ra;    // resetn_a expected at end of run
        logic  final_rc;
    } phase_t;

    phase_t tbl[3];

    initial begin
        tbl[0] = '{"power_on",  10, 40, 0, 1'b1, 1'b1};
        tbl[1] = '{"mid_async",  3, 40, 1, 1'b1, 1'b1};
        tbl[2] = '{"glitch",     0, 40, 0, 1'b1, 1'b1};
        // Instance c without the fast option needs 2+32 posedges.
        if (EC == 3) begin
            tbl[0].final_rc = 1'b0;
            tbl[1].final_rc = 1'b0;
            tbl[2].final_rc = 1'b0;
            tbl[0].run_cycles = 36;
            tbl[1].run_cycles = 36;
            tbl[2].run_cycles = 36;
            tbl[0].final_rc = 1'b1;
            tbl[1].final_rc = 1'b1;
            tbl[2].final_rc = 1'b1;
        end

        #2;
        check("reset_resetn_a", 0, resetn_a, 1'b0);
        check("reset_clk_a",    0, clk_a,    1'b0);

        for (int p = 0; p < 3; p++) begin
            run_seq({tbl[p].name, "_hold"}, tbl[p].hold_cycles, 1'b1);
            release_reset();
            run_seq(tbl[p].name, tbl[p].run_cycles, 1'b0);
            #2;
            check({tbl[p].name, "_final_resetn_a"}, tbl[p].run_cycles, resetn_a, tbl[p].final_ra);
            check({tbl[p].name, "_final_resetn_c"}, tbl[p].run_cycles, resetn_c, tbl[p].final_rc);
            if (tbl[p].glitch_ns > 0) begin
                // Short pulse: outputs drop at once, release re-synchronized.
                async_assert({tbl[p].name, "_pulse"}, tbl[p].glitch_ns);
                run_seq({tbl[p].name, "_after_pulse"}, tbl[p].run_cycles, 1'b0);
            end
            async_assert(tbl[p].name, 0);
        end

        // Release then re-assert before rst_sync rises: nothing may start.
        release_reset();
        @(posedge CLK);
        push_exp(1, 1'b1);
        #1 pop_cmp("early_k1");
        #1 RESET = 1'b0;
        run_seq("early_reassert", 12, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
